// File: rtl/usb_warmboot_sequencer.sv
// usb_warmboot_sequencer: drains USB TX, detaches D+, selects the image, then fires SB_WARMBOOT.
module usb_warmboot_sequencer #(
    parameter int         DETACH_CYCLES   = 4800000,
    parameter int         TXQUIET_CYCLES  = 96,
    parameter int         SETUP_CYCLES    = 16,
    parameter int         AUTOBOOT_CYCLES = 0,
    parameter logic [1:0] AUTOBOOT_IMAGE  = 2'd1,
    parameter int         CNT_W           = 24
) (
    input  logic       clk_48mhz,
    input  logic       reset,
    input  logic       boot_req,
    input  logic [1:0] boot_image,
    input  logic       usb_tx_en,
    input  logic       usb_activity,
    output logic       usb_pu,
    output logic       wb_s1,
    output logic       wb_s0,
    output logic       wb_boot,
    output logic       busy
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DRAIN  = 3'd1;
    localparam logic [2:0] S_DETACH = 3'd2;
    localparam logic [2:0] S_SETUP  = 3'd3;
    localparam logic [2:0] S_BOOT   = 3'd4;
    // Terminal count per timed state; a count of 0 still spends one cycle there.
    localparam logic [CNT_W-1:0] QUIET_LAST  = CNT_W'((TXQUIET_CYCLES  > 1) ? TXQUIET_CYCLES  - 1 : 0);
    localparam logic [CNT_W-1:0] DETACH_LAST = CNT_W'((DETACH_CYCLES   > 1) ? DETACH_CYCLES   - 1 : 0);
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'((SETUP_CYCLES    > 1) ? SETUP_CYCLES    - 1 : 0);
    localparam logic [CNT_W-1:0] AUTO_LAST   = CNT_W'((AUTOBOOT_CYCLES > 1) ? AUTOBOOT_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE     = 1;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic             AUTO_EN     = AUTOBOOT_CYCLES != 0;

    logic [2:0]       state, nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, last;
    logic [1:0]       img;
    logic             auto_hit, start, timer_done;

    assign auto_hit   = AUTO_EN && !usb_activity && !usb_tx_en && cnt == AUTO_LAST;
    assign start      = boot_req || auto_hit;
    assign last       = state == S_DRAIN ? QUIET_LAST : state == S_DETACH ? DETACH_LAST : SETUP_LAST;
    assign timer_done = cnt == last;

    // One counter serves as the idle auto-boot timer and as the per-state timer.
    always_comb begin
        nxt     = S_IDLE;
        cnt_nxt = '0;
        case (state)
            S_IDLE: begin
                nxt     = start ? S_DRAIN : S_IDLE;
                cnt_nxt = (start || usb_activity || usb_tx_en) ? '0 : cnt == CNT_MAX ? cnt : cnt + CNT_ONE;
            end
            S_DRAIN: begin
                nxt     = (!usb_tx_en && timer_done) ? S_DETACH : S_DRAIN;
                cnt_nxt = (usb_tx_en || timer_done) ? '0 : cnt + CNT_ONE;
            end
            S_DETACH: begin
                nxt     = timer_done ? S_SETUP : S_DETACH;
                cnt_nxt = timer_done ? '0 : cnt + CNT_ONE;
            end
            S_SETUP: begin
                nxt     = timer_done ? S_BOOT : S_SETUP;
                cnt_nxt = timer_done ? '0 : cnt + CNT_ONE;
            end
            S_BOOT:  nxt = S_BOOT;
            default: nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they move on the same edge as the FSM.
    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            img            <= 2'd0;
            usb_pu         <= 1'b1;
            {wb_s1, wb_s0} <= 2'b00;
            wb_boot        <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state   <= nxt;
            cnt     <= cnt_nxt;
            if (state == S_IDLE)
                img <= boot_req ? boot_image : auto_hit ? AUTOBOOT_IMAGE : img;
            usb_pu  <= nxt == S_IDLE || nxt == S_DRAIN;
            if (nxt == S_SETUP)
                {wb_s1, wb_s0} <= img;
            wb_boot <= nxt == S_BOOT;
            busy    <= nxt != S_IDLE;
        end
    end
endmodule

// File: tb/tb_usb_warmboot_sequencer.sv
// tb_usb_warmboot_sequencer: directed steps with hand-computed expectations on the output vector.
module tb_usb_warmboot_sequencer;
    logic       clk_48mhz = 1'b0;
    logic       reset = 1'b1;
    logic       boot_req = 1'b0;
    logic [1:0] boot_image = 2'd0;
    logic       usb_tx_en = 1'b0;
    logic       usb_activity = 1'b0;
    logic       usb_pu, wb_s1, wb_s0, wb_boot, busy;
    int         n_checks = 0;
    int         n_fail = 0;

    // Expected vectors are {busy, usb_pu, wb_s1, wb_s0, wb_boot}.
    localparam logic [4:0] O_IDLE   = 5'b01000;
    localparam logic [4:0] O_DRAIN  = 5'b11000;
    localparam logic [4:0] O_DETACH = 5'b10000;

    usb_warmboot_sequencer #(
        .DETACH_CYCLES(20), .TXQUIET_CYCLES(4), .SETUP_CYCLES(3),
        .AUTOBOOT_CYCLES(50), .AUTOBOOT_IMAGE(2'd1), .CNT_W(24)
    ) dut (
        .clk_48mhz(clk_48mhz), .reset(reset), .boot_req(boot_req), .boot_image(boot_image),
        .usb_tx_en(usb_tx_en), .usb_activity(usb_activity), .usb_pu(usb_pu),
        .wb_s1(wb_s1), .wb_s0(wb_s0), .wb_boot(wb_boot), .busy(busy)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_48mhz);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {busy, usb_pu, wb_s1, wb_s0, wb_boot};
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset and quiet idle
        tick(2);
        check("reset", O_IDLE);
        reset = 1'b0;
        tick(10);
        check("idle10", O_IDLE);
        // 2 + 5: explicit boot to image 2, late request for image 3 during DETACH ignored
        boot_image = 2'd2;
        boot_req = 1'b1;
        tick(1);
        boot_req = 1'b0;
        boot_image = 2'd0;
        check("drain_entry", O_DRAIN);
        tick(3);
        check("drain_3quiet", O_DRAIN);
        tick(1);
        check("detach_entry", O_DETACH);
        tick(5);
        boot_req = 1'b1;
        boot_image = 2'd3;
        usb_tx_en = 1'b1;
        tick(1);
        boot_req = 1'b0;
        tick(2);
        usb_tx_en = 1'b0;
        tick(11);
        check("detach_last", O_DETACH);
        tick(1);
        check("setup_img2", 5'b10100);
        tick(2);
        check("setup_last", 5'b10100);
        tick(1);
        check("boot_img2", 5'b10101);
        tick(10);
        check("boot_held", 5'b10101);
        // 6a: reset out of BOOT
        reset = 1'b1;
        tick(1);
        check("reset_in_boot", O_IDLE);
        reset = 1'b0;
        // 3: TX activity keeps DRAIN from detaching
        boot_image = 2'd3;
        boot_req = 1'b1;
        tick(1);
        boot_req = 1'b0;
        check("drain2_entry", O_DRAIN);
        for (int i = 0; i < 30; i++) begin
            usb_tx_en = ((i / 3) % 2) == 0;
            tick(1);
        end
        usb_tx_en = 1'b0;
        check("drain_toggle", O_DRAIN);
        tick(1);
        check("detach_after_quiet", O_DETACH);
        tick(20);
        check("setup_img3", 5'b10110);
        // 6a: reset out of SETUP
        reset = 1'b1;
        tick(1);
        check("reset_in_setup", O_IDLE);
        reset = 1'b0;
        // 4: auto-boot, restarted by an activity pulse at cycle 45
        tick(44);
        usb_activity = 1'b1;
        tick(1);
        usb_activity = 1'b0;
        tick(49);
        check("auto_not_yet", O_IDLE);
        tick(1);
        check("auto_fire", O_DRAIN);
        tick(4);
        check("auto_detach", O_DETACH);
        tick(20);
        check("auto_setup_img1", 5'b10010);
        tick(3);
        check("auto_boot_img1", 5'b10011);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("reset_auto_boot", O_IDLE);
        // 6b: explicit request coincides with auto-boot expiry
        tick(49);
        check("coincide_pre", O_IDLE);
        boot_image = 2'd2;
        boot_req = 1'b1;
        tick(1);
        boot_req = 1'b0;
        check("coincide_drain", O_DRAIN);
        tick(24);
        check("coincide_setup_img2", 5'b10100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
